// File: rtl/servo_pkg.sv
// Shared servo channel definitions: state encoding, default timing constants and angle conversion.
// Also used by the PWM generator and the other joint channels.
package servo_pkg;

  localparam int unsigned ONTIME_W    = 28;
  localparam int unsigned ANGLE_W     = 8;
  localparam int unsigned CNT_MIN     = 100000;
  localparam int unsigned CNT_PER_DEG = 555;
  localparam int unsigned ANGLE_MAX   = 180;
  localparam int unsigned FRAME_CNT   = 2000000;
  localparam int unsigned RAMP_STEP   = 5550;

  typedef logic [ONTIME_W-1:0] ontime_t;
  typedef logic [ANGLE_W-1:0]  angle_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RAMP = 2'd2,
    HOLD = 2'd3
  } servo_state_e;

  // Clamp the requested angle and convert it to an on-time count.
  function automatic ontime_t angle_to_count(input angle_t angle, input angle_t angle_max,
                                             input ontime_t cnt_min, input ontime_t per_deg);
    angle_t a;
    if (angle > angle_max) begin
      a = angle_max;
    end else begin
      a = angle;
    end
    return cnt_min + (ontime_t'(a) * per_deg);
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running wrap counter 0..PERIOD-1 emitting a one-cycle tick on the last count.
// Reusable per joint channel.
module frame_tick_gen #(
  parameter int unsigned PERIOD = 2000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST_C = CW'(PERIOD - 1);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  logic [CW-1:0] cnt_r;

  // Frame counter, wraps after the last count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (cnt_r == LAST_C) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + ONE_C;
    end
  end

  assign tick = (cnt_r == LAST_C);

endmodule

// File: rtl/servo_ontime_ramp.sv
// Converts a commanded joint angle into a PWM on-time count and slews the driven on-time toward it.
// Build option SERVO_RAMP_EN: defined = per-frame slew limit; undefined = target loaded directly.
module servo_ontime_ramp #(
  parameter int unsigned CNT_MIN     = servo_pkg::CNT_MIN,
  parameter int unsigned CNT_PER_DEG = servo_pkg::CNT_PER_DEG,
  parameter int unsigned ANGLE_MAX   = servo_pkg::ANGLE_MAX,
  parameter int unsigned FRAME_CNT   = servo_pkg::FRAME_CNT,
  parameter int unsigned RAMP_STEP   = servo_pkg::RAMP_STEP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_angle,
  output logic [27:0] ontime,
  output logic        busy,
  output logic        clamp_err
);

  import servo_pkg::*;

  localparam angle_t  AMAX_C = ANGLE_W'(ANGLE_MAX);
  localparam ontime_t CMIN_C = ONTIME_W'(CNT_MIN);
  localparam ontime_t PDEG_C = ONTIME_W'(CNT_PER_DEG);

  servo_state_e state_r, state_s;
  ontime_t      target_r, ontime_r, ontime_s;
  logic         busy_r, clamp_err_r, ready_r;
  logic         xfer_s;

  assign xfer_s = cmd_valid & ready_r;

`ifdef SERVO_RAMP_EN
  localparam ontime_t STEP_C = ONTIME_W'(RAMP_STEP);

  logic    tick_s;
  ontime_t diff_s, ramp_s;

  frame_tick_gen #(.PERIOD(FRAME_CNT)) u_frame_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_s)
  );

  // One slew step toward the target, landing exactly on it when within reach
  always_comb begin
    diff_s = '0;
    ramp_s = ontime_r;
    if (target_r >= ontime_r) begin
      diff_s = target_r - ontime_r;
      if (diff_s <= STEP_C) begin
        ramp_s = target_r;
      end else begin
        ramp_s = ontime_r + STEP_C;
      end
    end else begin
      diff_s = ontime_r - target_r;
      if (diff_s <= STEP_C) begin
        ramp_s = target_r;
      end else begin
        ramp_s = ontime_r - STEP_C;
      end
    end
  end
`endif

  // Next state and next on-time
  always_comb begin
    state_s  = state_r;
    ontime_s = ontime_r;
    case (state_r)
      IDLE: begin
        if (xfer_s) state_s = CALC;
        else        state_s = IDLE;
      end
      CALC: begin
`ifdef SERVO_RAMP_EN
        // A limp servo jumps straight to its first target; ticks are ignored here
        if (ontime_r == '0) begin
          ontime_s = target_r;
          state_s  = HOLD;
        end else if (ontime_r != target_r) begin
          state_s  = RAMP;
        end else begin
          state_s  = HOLD;
        end
`else
        ontime_s = target_r;
        state_s  = HOLD;
`endif
      end
      RAMP: begin
`ifdef SERVO_RAMP_EN
        if (tick_s) ontime_s = ramp_s;
        else        ontime_s = ontime_r;
        if (xfer_s)                    state_s = CALC;
        else if (ontime_s == target_r) state_s = HOLD;
        else                           state_s = RAMP;
`else
        state_s = HOLD;
`endif
      end
      HOLD: begin
        if (xfer_s) state_s = CALC;
        else        state_s = HOLD;
      end
      default: begin
        state_s  = IDLE;
        ontime_s = '0;
      end
    endcase
  end

  // State, target and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      ontime_r    <= '0;
      target_r    <= '0;
      busy_r      <= 1'b0;
      clamp_err_r <= 1'b0;
      ready_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      ontime_r    <= ontime_s;
      if (xfer_s) begin
        target_r  <= angle_to_count(cmd_angle, AMAX_C, CMIN_C, PDEG_C);
      end
      clamp_err_r <= xfer_s & (cmd_angle > AMAX_C);
      busy_r      <= (state_s == CALC) || (state_s == RAMP);
      ready_r     <= (state_s != CALC);
    end
  end

  assign cmd_ready = ready_r;
  assign ontime    = ontime_r;
  assign busy      = busy_r;
  assign clamp_err = clamp_err_r;

endmodule

// File: tb/tb_servo_ontime_ramp.sv
// Self-checking bench: directed scenarios plus random commands against a cycle-level reference model.
// Follows the SERVO_RAMP_EN build option of the design.
module tb_servo_ontime_ramp;

  localparam int F = 100;
  localparam int S = 5550;
`ifdef SERVO_RAMP_EN
  localparam bit RAMP_ON = 1'b1;
`else
  localparam bit RAMP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_angle;
  logic [27:0] ontime;
  logic        busy;
  logic        clamp_err;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_ontime, m_target, m_edge;
  bit m_ready, m_calc, m_clamp;

  always #5 clk = ~clk;

  servo_ontime_ramp #(.FRAME_CNT(F)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_angle (cmd_angle),
    .ontime    (ontime),
    .busy      (busy),
    .clamp_err (clamp_err)
  );

  function automatic int deg2cnt(input int a);
    return 100000 + ((a > 180) ? 180 : a) * 555;
  endfunction

  function automatic int approach(input int o, input int t);
    if (t > o) return (t - o <= S) ? t : o + S;
    else       return (o - t <= S) ? t : o - S;
  endfunction

  // Reference: ontime moves toward target by at most S per frame, first load is immediate
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ontime <= 0; m_target <= 0; m_edge <= 0;
      m_ready <= 1'b0; m_calc <= 1'b0; m_clamp <= 1'b0;
    end else begin
      m_edge  <= m_edge + 1;
      m_ready <= !(cmd_valid && m_ready);
      m_calc  <= cmd_valid && m_ready;
      m_clamp <= cmd_valid && m_ready && (cmd_angle > 8'd180);
      if (cmd_valid && m_ready) m_target <= deg2cnt(int'(cmd_angle));
      if (m_calc) begin
        if (!RAMP_ON || m_ontime == 0) m_ontime <= m_target;
      end else if (RAMP_ON && (m_edge % F == F - 1)) begin
        m_ontime <= approach(m_ontime, m_target);
      end
    end
  end

  task automatic check_val(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_val("ontime", ontime, m_ontime);
    check_val("busy", busy, (m_calc || m_ontime != m_target) ? 1 : 0);
    check_val("clamp_err", clamp_err, m_clamp);
    check_val("cmd_ready", cmd_ready, m_ready);
  endtask

  task automatic send(input int a, output int tries);
    bit done;
    done = 1'b0;
    tries = 0;
    cmd_angle = 8'(a);
    cmd_valid = 1'b1;
    for (int i = 0; i < 10 && !done; i++) begin
      done = cmd_ready;
      tries++;
      step();
    end
    cmd_valid = 1'b0;
    check_val("xfer", done, 1);
  endtask

  task automatic wait_idle();
    bit got;
    got = !busy;
    for (int i = 0; i < 40 * F && !got; i++) begin
      step();
      got = !busy;
    end
    check_val("idle_seen", got, 1);
  endtask

  task automatic wait_change(output int v);
    int old;
    bit got;
    old = int'(ontime);
    got = 1'b0;
    for (int i = 0; i < 3 * F && !got; i++) begin
      step();
      if (int'(ontime) != old) got = 1'b1;
    end
    check_val("change_seen", got, 1);
    v = int'(ontime);
  endtask

  initial begin
    int tries, v, n, mn;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_angle = 8'd0;
    step();
    check_val("rst_ontime", ontime, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_clamp", clamp_err, 0);
    check_val("rst_ready", cmd_ready, 0);
    step();
    rst = 1'b0;
    step();

    // first command loads directly
    send(90, tries);
    check_val("t1_clamp", clamp_err, 0);
    check_val("t1_busy_calc", busy, 1);
    step();
    check_val("t1_ontime", ontime, 149950);
    check_val("t1_busy_after", busy, 0);
    step();

`ifdef SERVO_RAMP_EN
    // downward ramp, 9 frames to the 0 deg count
    send(0, tries);
    wait_change(v);
    check_val("t2_first_step", v, 144400);
    n = 1;
    mn = v;
    while (v != 100000 && n < 20) begin
      wait_change(v);
      n++;
      if (v < mn) mn = v;
    end
    check_val("t2_ticks", n, 9);
    check_val("t2_final", v, 100000);
    check_val("t2_min", mn, 100000);
    check_val("t2_busy_fall", busy, 0);
`endif

    // clamped angle
    send(200, tries);
    check_val("t3_clamp_pulse", clamp_err, 1);
    step();
    check_val("t3_clamp_clear", clamp_err, 0);
    wait_idle();
    check_val("t3_ontime", ontime, 199900);

`ifdef SERVO_RAMP_EN
    // retarget mid-ramp reverses direction
    send(0, tries);
    wait_idle();
    send(180, tries);
    for (int i = 0; i < 6; i++) wait_change(v);
    check_val("t4_mid", v, 133300);
    send(45, tries);
    check_val("t4_no_stall", tries, 1);
    wait_change(v);
    check_val("t4_rev1", v, 127750);
    wait_change(v);
    check_val("t4_rev2", v, 124975);
    check_val("t4_busy", busy, 0);

    // async reset in the middle of a ramp
    send(180, tries);
    wait_change(v);
    wait_change(v);
`else
    // direct load without ramp
    send(0, tries);
    step();
    check_val("t6_zero", ontime, 100000);
    send(180, tries);
    step();
    check_val("t6_full", ontime, 199900);
    check_val("t6_busy", busy, 0);
    send(90, tries);
`endif
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_val("t5_rst_ontime", ontime, 0);
    check_val("t5_rst_busy", busy, 0);
    step();
    rst = 1'b0;
    send(30, tries);
    step();
    check_val("t5_reload", ontime, 116650);

    // random commands, sometimes mid-ramp
    for (int k = 0; k < 14; k++) begin
      int gap;
      gap = int'($urandom_range(0, 3 * F));
      for (int j = 0; j < gap; j++) step();
      send(int'($urandom_range(0, 255)), tries);
    end
    wait_idle();
    for (int j = 0; j < 5; j++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
